// File: rtl/adder_pkg.sv
// Shared constants and parameter helpers for the pipelined N-bit adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth.
//   params_legal()                 : legality of a WIDTH/STAGES pair.
//   slice_width()                  : bits added per stage (WIDTH/STAGES).
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    // WIDTH must be 2..64 and split evenly into 1..WIDTH stages.
    function automatic bit params_legal(input int width, input int stages);
        return (width >= 2) && (width <= 64) &&
               (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

    // Falls back to 1 for an illegal pair so that elaboration reaches the
    // explicit $error in the top level rather than tripping on a zero width.
    function automatic int slice_width(input int width, input int stages);
        if (params_legal(width, stages)) begin
            return width / stages;
        end
        return 1;
    endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result handshake bundle for pipelined_adder_nbit.
// Latency: n/a (wires only).
// Backpressure: o_ready/i_ready valid-ready pairs on input and output side.
//
// Signals:
//   i_1, i_2, i_c, i_valid : operand beat into the adder, o_ready back.
//   o_s, o_c, o_valid      : result beat out of the adder, i_ready back.
//   o_v                    : signed overflow, only with ADDER_OVERFLOW_EN.
// Modports: slave = the adder, master = the agent driving it.
interface pipelined_adder_nbit_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] i_1;
    logic [WIDTH-1:0] i_2;
    logic             i_c;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_c;
    logic             o_valid;
    logic             i_ready;
`ifdef ADDER_OVERFLOW_EN
    logic             o_v;

    modport slave (
        input  i_1, i_2, i_c, i_valid, i_ready,
        output o_ready, o_s, o_c, o_valid, o_v
    );

    modport master (
        output i_1, i_2, i_c, i_valid, i_ready,
        input  o_ready, o_s, o_c, o_valid, o_v
    );
`else
    modport slave (
        input  i_1, i_2, i_c, i_valid, i_ready,
        output o_ready, o_s, o_c, o_valid
    );

    modport master (
        output i_1, i_2, i_c, i_valid, i_ready,
        input  o_ready, o_s, o_c, o_valid
    );
`endif

endinterface

// File: rtl/adder_slice.sv
// Purely combinational SLICE-bit ripple-carry adder built from 1-bit full adders.
// Latency: 0 cycles (combinational).
// Backpressure: none; the enclosing pipeline stage decides when to capture.
//
// Ports:
//   a, b : SLICE-bit operand slices
//   ci   : carry into bit 0
//   s    : SLICE-bit sum slice
//   co   : carry out of bit SLICE-1
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    // carry[i] is the carry into bit i; carry[SLICE] leaves the slice.
    logic [SLICE:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign co = carry[SLICE];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit adder: {o_c,o_s} = i_1 + i_2 + i_c, one SLICE per stage.
// Latency: STAGES cycles from the accepting edge; one beat per cycle throughput.
// Backpressure: a single advance enable (!o_valid || i_ready) freezes every stage.
//
// Ports:
//   i_clk : clock, all state on its rising edge
//   i_rst : asynchronous active-high reset, clears valids and outputs
//   bus   : pipelined_adder_nbit_if.slave (operands in, sum/carry out)
// Optional feature: define ADDER_OVERFLOW_EN to add bus.o_v, the signed
// two's-complement overflow flag, registered alongside o_valid.
module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pipelined_adder_nbit_if.slave bus
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder_nbit: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    // The whole pipe moves as one: either the output slot is empty or it is
    // being taken this cycle. Any other case freezes every stage, so beats
    // never overtake or collide, and bubbles simply ride along.
    logic adv;
    logic out_vld;

    assign adv         = !out_vld || bus.i_ready;
    assign bus.o_ready = adv;

    // Stage k adds bits [k*SLICE +: SLICE]. Its input operand is the part of
    // the original operand not yet consumed (IN_W bits, LSB = this slice);
    // it registers the part above its slice (REM_W bits) for the next stage,
    // plus the growing sum (LO+SLICE bits) and its carry-out.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO    = k * SLICE;
        localparam int IN_W  = WIDTH - LO;
        localparam int REM_W = IN_W - SLICE;

        logic [IN_W-1:0]     a_in;
        logic [IN_W-1:0]     b_in;
        logic                ci_in;
        logic                vld_in;
        logic [SLICE-1:0]    slice_s;
        logic                slice_co;
        logic [LO+SLICE-1:0] sum_next;

        logic                vld_q;
        logic                vld_d;
        logic                cy_q;
        logic                cy_d;
        logic [LO+SLICE-1:0] sum_q;
        logic [LO+SLICE-1:0] sum_d;

        if (k == 0) begin : g_head
            assign a_in     = bus.i_1;
            assign b_in     = bus.i_2;
            assign ci_in    = bus.i_c;
            assign vld_in   = bus.i_valid;
            assign sum_next = slice_s;
        end else begin : g_body
            assign a_in     = g_stage[k-1].g_rem.a_q;
            assign b_in     = g_stage[k-1].g_rem.b_q;
            assign ci_in    = g_stage[k-1].cy_q;
            assign vld_in   = g_stage[k-1].vld_q;
            // Lower sum slices finished by earlier stages travel with the beat.
            assign sum_next = {slice_s, g_stage[k-1].sum_q};
        end

        adder_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a  (a_in[SLICE-1:0]),
            .b  (b_in[SLICE-1:0]),
            .ci (ci_in),
            .s  (slice_s),
            .co (slice_co)
        );

        // Data is captured even for bubbles; only vld_q gives it meaning.
        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            sum_d = sum_q;
            if (adv) begin
                vld_d = vld_in;
                cy_d  = slice_co;
                sum_d = sum_next;
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        // Operand bits above this slice are delayed so they meet their
        // carry in the stage that consumes them. The last stage has none.
        if (REM_W > 0) begin : g_rem
            logic [REM_W-1:0] a_q;
            logic [REM_W-1:0] a_d;
            logic [REM_W-1:0] b_q;
            logic [REM_W-1:0] b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    a_d = a_in[IN_W-1:SLICE];
                    b_d = b_in[IN_W-1:SLICE];
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef ADDER_OVERFLOW_EN
        // The last stage sees both operand MSBs and produces the sum MSB, so
        // overflow is resolved here and registered with the final result.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_now;
            logic ovf_q;
            logic ovf_d;

            assign ovf_now = (a_in[IN_W-1] == b_in[IN_W-1]) &&
                             (slice_s[SLICE-1] != a_in[IN_W-1]);

            always_comb begin
                ovf_d = ovf_q;
                if (adv) begin
                    ovf_d = ovf_now;
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign out_vld     = g_stage[STAGES-1].vld_q;
    assign bus.o_valid = out_vld;
    assign bus.o_s     = g_stage[STAGES-1].sum_q;
    assign bus.o_c     = g_stage[STAGES-1].cy_q;
`ifdef ADDER_OVERFLOW_EN
    assign bus.o_v     = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
